// File: rtl/mem_stage.sv
// MEM stage of the 5-stage pipeline: word loads/stores against an internal
// synchronous data memory, registering the MEM/WB bundle for wb_stage.
module mem_stage #(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ex_valid,
   input  logic [31:0] ex_alu_result,
   input  logic [31:0] ex_store_data,
   input  logic        ex_mem_read,
   input  logic        ex_mem_write,
   input  logic        ex_mem_to_reg,
   input  logic        ex_reg_write,
   input  logic [4:0]  ex_rd,
   input  logic        stall,
   input  logic        flush,
   output logic        mem_to_reg,
   output logic [31:0] data_in,
   output logic [31:0] dir,
   output logic        reg_write,
   output logic [4:0]  rd,
   output logic        wb_valid,
   output logic        align_err,
   output logic [15:0] load_count,
   output logic [15:0] store_count
);

   logic [31:0]       mem [DEPTH];
   logic [ADDR_W-1:0] word_idx;
   logic              misaligned;
   logic              legal;
   logic              acc;
   logic              do_load;
   logic              do_store;

   assign word_idx   = ex_alu_result[ADDR_W+1:2];
   assign misaligned = (ex_alu_result[1:0] != 2'b00) && (ex_mem_read || ex_mem_write);
   assign legal      = !misaligned && !(ex_mem_read && ex_mem_write);
   assign acc        = ex_valid && !stall && !flush;
   assign do_load    = acc && ex_mem_read && legal;
   assign do_store   = acc && ex_mem_write && legal;

   // Memory array has no reset; a store coinciding with reset is dropped.
   always_ff @(posedge clk) begin
      if (!reset && do_store) begin
         mem[word_idx] <= ex_store_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_to_reg  <= 1'b0;
         data_in     <= 32'd0;
         dir         <= 32'd0;
         reg_write   <= 1'b0;
         rd          <= 5'd0;
         wb_valid    <= 1'b0;
         align_err   <= 1'b0;
         load_count  <= 16'd0;
         store_count <= 16'd0;
      end else if (flush) begin
         wb_valid   <= 1'b0;
         reg_write  <= 1'b0;
         mem_to_reg <= 1'b0;
      end else if (stall) begin
         wb_valid <= wb_valid;
      end else if (ex_valid) begin
         dir        <= ex_alu_result;
         rd         <= ex_rd;
         mem_to_reg <= ex_mem_to_reg;
         reg_write  <= ex_reg_write && legal;
         wb_valid   <= 1'b1;
         data_in    <= do_load ? mem[word_idx] : 32'd0;
         if (!legal) begin
            align_err <= 1'b1;
         end
         if (do_load) begin
            load_count <= load_count + 16'd1;
         end
         if (do_store) begin
            store_count <= store_count + 16'd1;
         end
      end else begin
         wb_valid   <= 1'b0;
         reg_write  <= 1'b0;
         mem_to_reg <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ex_valid = 1'b0;
   logic [31:0] ex_alu_result = 32'd0;
   logic [31:0] ex_store_data = 32'd0;
   logic        ex_mem_read = 1'b0;
   logic        ex_mem_write = 1'b0;
   logic        ex_mem_to_reg = 1'b0;
   logic        ex_reg_write = 1'b0;
   logic [4:0]  ex_rd = 5'd0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        mem_to_reg;
   logic [31:0] data_in;
   logic [31:0] dir;
   logic        reg_write;
   logic [4:0]  rd;
   logic        wb_valid;
   logic        align_err;
   logic [15:0] load_count;
   logic [15:0] store_count;

   int checks = 0;
   int errors = 0;
   bit checkEn = 1'b0;

   // Behavioural model state: memory image plus the expected MEM/WB outputs.
   logic [31:0] mMem [256];
   logic        eMtr = 1'b0;
   logic [31:0] eData = 32'd0;
   logic [31:0] eDir = 32'd0;
   logic        eRw = 1'b0;
   logic [4:0]  eRd = 5'd0;
   logic        eWbv = 1'b0;
   logic        eErr = 1'b0;
   logic [15:0] eLc = 16'd0;
   logic [15:0] eSc = 16'd0;

   mem_stage #(.DEPTH(256), .ADDR_W(8)) dut (
      .clk(clk), .reset(reset), .ex_valid(ex_valid),
      .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write),
      .ex_rd(ex_rd), .stall(stall), .flush(flush),
      .mem_to_reg(mem_to_reg), .data_in(data_in), .dir(dir),
      .reg_write(reg_write), .rd(rd), .wb_valid(wb_valid),
      .align_err(align_err), .load_count(load_count), .store_count(store_count)
   );

   always #5 clk = ~clk;

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Advance the model by one clock using the inputs presented at that edge.
   task automatic modelStep();
      bit illegal;
      int unsigned w;
      if (reset) begin
         eMtr = 0; eData = 0; eDir = 0; eRw = 0; eRd = 0;
         eWbv = 0; eErr = 0; eLc = 0; eSc = 0;
      end else if (flush) begin
         eWbv = 0; eRw = 0; eMtr = 0;
      end else if (stall) begin
         eWbv = eWbv;
      end else if (!ex_valid) begin
         eWbv = 0; eRw = 0; eMtr = 0;
      end else begin
         illegal = ((ex_mem_read || ex_mem_write) && (ex_alu_result % 4 != 0))
                   || (ex_mem_read && ex_mem_write);
         w = (ex_alu_result / 4) % 256;
         if (illegal) eErr = 1;
         if (ex_mem_write && !illegal) begin
            mMem[w] = ex_store_data;
            eSc = eSc + 1;
         end
         if (ex_mem_read && !illegal) begin
            eData = mMem[w];
            eLc = eLc + 1;
         end else begin
            eData = 0;
         end
         eDir = ex_alu_result;
         eRd  = ex_rd;
         eMtr = ex_mem_to_reg;
         eRw  = ex_reg_write && !illegal;
         eWbv = 1;
      end
   endtask

   task automatic applyStimulus(input bit rst, input bit v, input logic [31:0] addr,
                                input logic [31:0] sdata, input bit rdEn, input bit wrEn,
                                input bit mtr, input bit rw, input logic [4:0] dst,
                                input bit st, input bit fl);
      reset = rst; ex_valid = v; ex_alu_result = addr; ex_store_data = sdata;
      ex_mem_read = rdEn; ex_mem_write = wrEn; ex_mem_to_reg = mtr;
      ex_reg_write = rw; ex_rd = dst; stall = st; flush = fl;
      @(posedge clk);
      modelStep();
      #1;
      checkEn = 1'b1;
   endtask

   task automatic doStore(input logic [31:0] addr, input logic [31:0] data);
      applyStimulus(0, 1, addr, data, 0, 1, 0, 0, 5'd0, 0, 0);
   endtask

   task automatic doLoad(input logic [31:0] addr, input logic [4:0] dst);
      applyStimulus(0, 1, addr, 32'd0, 1, 0, 1, 1, dst, 0, 0);
   endtask

   task automatic checkOutput();
      checkVal("mem_to_reg", {31'd0, mem_to_reg}, {31'd0, eMtr});
      checkVal("data_in", data_in, eData);
      checkVal("dir", dir, eDir);
      checkVal("reg_write", {31'd0, reg_write}, {31'd0, eRw});
      checkVal("rd", {27'd0, rd}, {27'd0, eRd});
      checkVal("wb_valid", {31'd0, wb_valid}, {31'd0, eWbv});
      checkVal("align_err", {31'd0, align_err}, {31'd0, eErr});
      checkVal("load_count", {16'd0, load_count}, {16'd0, eLc});
      checkVal("store_count", {16'd0, store_count}, {16'd0, eSc});
   endtask

   always @(negedge clk) begin
      if (checkEn) checkOutput();
   end

   initial begin
      logic [31:0] addr;
      bit isRd, isWr;
      int op;

      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkVal("reset_wb_valid", {31'd0, wb_valid}, 32'd0);
      checkVal("reset_store_count", {16'd0, store_count}, 32'd0);

      // Give every word a known value, then reset: contents must survive reset.
      for (int i = 0; i < 256; i++) doStore(i * 4, 32'hC0DE0000 | i);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      doStore(32'h04, 32'hAAAAAAAA);
      doLoad(32'h04, 5'd5);
      checkVal("ld_data", data_in, 32'hAAAAAAAA);
      checkVal("ld_dir", dir, 32'h04);
      checkVal("ld_rd", {27'd0, rd}, 32'd5);
      checkVal("ld_reg_write", {31'd0, reg_write}, 32'd1);
      checkVal("ld_mem_to_reg", {31'd0, mem_to_reg}, 32'd1);
      checkVal("ld_store_count", {16'd0, store_count}, 32'd1);
      checkVal("ld_load_count", {16'd0, load_count}, 32'd1);

      applyStimulus(0, 1, 32'h0000FFFF, 0, 0, 0, 0, 1, 5'd3, 0, 0);
      checkVal("alu_dir", dir, 32'h0000FFFF);
      checkVal("alu_data", data_in, 32'd0);
      checkVal("alu_mem_to_reg", {31'd0, mem_to_reg}, 32'd0);
      checkVal("alu_reg_write", {31'd0, reg_write}, 32'd1);

      for (int k = 0; k < 3; k++) begin
         applyStimulus(0, 1, 32'h04, 0, 1, 0, 1, 1, 5'd7, 1, 0);
         checkVal("stall_dir", dir, 32'h0000FFFF);
         checkVal("stall_data", data_in, 32'd0);
         checkVal("stall_load_count", {16'd0, load_count}, 32'd1);
      end
      doLoad(32'h04, 5'd7);
      checkVal("unstall_data", data_in, 32'hAAAAAAAA);
      checkVal("unstall_load_count", {16'd0, load_count}, 32'd2);

      applyStimulus(0, 1, 32'h08, 32'h12345678, 0, 1, 0, 0, 5'd0, 0, 1);
      checkVal("flush_wb_valid", {31'd0, wb_valid}, 32'd0);
      doLoad(32'h08, 5'd1);
      checkVal("flush_dropped", data_in, 32'hC0DE0002);

      applyStimulus(0, 1, 32'h06, 32'h99999999, 0, 1, 0, 1, 5'd2, 0, 0);
      checkVal("mis_align_err", {31'd0, align_err}, 32'd1);
      checkVal("mis_store_count", {16'd0, store_count}, 32'd1);
      checkVal("mis_reg_write", {31'd0, reg_write}, 32'd0);
      checkVal("mis_wb_valid", {31'd0, wb_valid}, 32'd1);
      doLoad(32'h04, 5'd4);
      checkVal("mis_mem_kept", data_in, 32'hAAAAAAAA);
      applyStimulus(0, 1, 32'h04, 0, 1, 1, 1, 1, 5'd4, 0, 0);
      checkVal("rw_align_err", {31'd0, align_err}, 32'd1);
      checkVal("rw_reg_write", {31'd0, reg_write}, 32'd0);

      doStore(32'h400, 32'hDEADBEEF);
      doLoad(32'h000, 5'd6);
      checkVal("wrap_data", data_in, 32'hDEADBEEF);

      applyStimulus(1, 1, 32'h10, 32'h55, 0, 1, 0, 1, 5'd9, 1, 1);
      checkVal("rst_dir", dir, 32'd0);
      checkVal("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
      checkVal("rst_store_count", {16'd0, store_count}, 32'd0);
      checkVal("rst_align_err", {31'd0, align_err}, 32'd0);
      doLoad(32'h10, 5'd8);
      checkVal("rst_store_dropped", data_in, 32'hC0DE0004);

      // Random traffic concentrated on a few words so stores and loads collide.
      for (int n = 0; n < 3000; n++) begin
         op = $urandom_range(0, 2);
         isRd = (op == 0);
         isWr = (op == 1);
         if ($urandom_range(0, 31) == 0) begin isRd = 1; isWr = 1; end
         addr = ($urandom_range(0, 15) * 4) | ($urandom_range(0, 3) << 10);
         if ($urandom_range(0, 15) == 0) addr[1:0] = 2'($urandom_range(0, 3));
         if (op == 2) addr = $urandom;
         applyStimulus($urandom_range(0, 99) < 2, $urandom_range(0, 9) != 0, addr,
                       $urandom, isRd, isWr, 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                       $urandom_range(0, 9) == 0, $urandom_range(0, 14) == 0);
      end

      @(negedge clk);
      checkEn = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
